instr_issuer: RTL and testbench

INSTR_ISSUER -- requirements
Module: instr_issuer

---
 rtl/instr_issuer_if.sv | 25 ++
 rtl/instr_issuer.sv | 202 ++++++++++++++++++++
 tb/tb_instr_issuer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issuer_if.sv
// Instruction issuer bus: instruction ROM read port plus processor launch handshake.
// master = issuer side, slave = ROM/processor side.
interface instr_issuer_if;
   logic [4:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] din;
   logic       run_sig;
   logic       done_sig;

   modport master (
      output rom_addr,
      output din,
      output run_sig,
      input  rom_data,
      input  done_sig
   );

   modport slave (
      input  rom_addr,
      input  din,
      input  run_sig,
      output rom_data,
      output done_sig
   );
endinterface

// File: rtl/instr_issuer.sv
// instr_issuer: fetches instruction words (and MVI immediates) from a 32-entry ROM
// with one cycle of read latency, launches each instruction with a one-cycle RUN_SIG
// pulse and waits in EXEC for the processor's DONE_SIG. Opcode 3'b111 halts the run.
// Optional EXEC watchdog: define INSTR_ISSUER_WATCHDOG_EN to add a 16-cycle timeout
// that halts the issuer and raises o_wdt_err.
// All outputs are registered; their next values are derived from the next state so
// that each output is already valid in the first cycle of the state it belongs to.
module instr_issuer (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_start,
   instr_issuer_if.master io_bus,
   output logic           o_busy,
   output logic           o_halted,
   output logic [4:0]     o_pc
`ifdef INSTR_ISSUER_WATCHDOG_EN
   ,
   output logic           o_wdt_err
`endif
);

   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_LATCH     = 3'd2,
      S_IMM_FETCH = 3'd3,
      S_IMM_LATCH = 3'd4,
      S_ISSUE     = 3'd5,
      S_EXEC      = 3'd6,
      S_HALT      = 3'd7
   } state_t;

   state_t     r_state;
   state_t     w_next_state;
   logic [4:0] r_pc,       w_pc_nxt;
   logic [4:0] r_rom_addr, w_rom_addr_nxt;
   logic [7:0] r_ir,       w_ir_nxt;
   logic [7:0] r_imm,      w_imm_nxt;
   logic [7:0] r_din,      w_din_nxt;
   logic       r_run,      w_run_nxt;
   logic       r_busy,     w_busy_nxt;
   logic       r_halted,   w_halted_nxt;
   logic [2:0] w_rom_op;
   logic [2:0] w_ir_op;
   logic       w_ir_is_mvi;

   assign w_rom_op    = io_bus.rom_data[7:5];
   assign w_ir_op     = r_ir[7:5];
   assign w_ir_is_mvi = (w_ir_op == OP_MVI);

`ifdef INSTR_ISSUER_WATCHDOG_EN
   logic [4:0] r_wdt_cnt, w_wdt_cnt_nxt;
   logic       r_wdt_err, w_wdt_err_nxt;
   logic       w_wdt_expire;

   // The 16th EXEC cycle without DONE_SIG is the timeout cycle (counter cleared on entry).
   assign w_wdt_expire = (r_state == S_EXEC) && !io_bus.done_sig && (r_wdt_cnt == 5'd15);
`endif

   // State register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; START only matters in IDLE/HALT, DONE_SIG only in EXEC.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next_state = S_FETCH;
            else         w_next_state = S_IDLE;
         end
         S_FETCH:     w_next_state = S_LATCH;
         S_LATCH: begin
            if (w_rom_op == OP_HALT)     w_next_state = S_HALT;
            else if (w_rom_op == OP_MVI) w_next_state = S_IMM_FETCH;
            else                         w_next_state = S_ISSUE;
         end
         S_IMM_FETCH: w_next_state = S_IMM_LATCH;
         S_IMM_LATCH: w_next_state = S_ISSUE;
         S_ISSUE:     w_next_state = S_EXEC;
         S_EXEC: begin
            if (io_bus.done_sig)   w_next_state = S_FETCH;
`ifdef INSTR_ISSUER_WATCHDOG_EN
            else if (w_wdt_expire) w_next_state = S_HALT;
`endif
            else                   w_next_state = S_EXEC;
         end
         S_HALT: begin
            if (i_start) w_next_state = S_FETCH;
            else         w_next_state = S_HALT;
         end
         default:     w_next_state = S_IDLE;
      endcase
   end

   // Output/datapath next values; PC is computed first because ROM_ADDR follows it.
   always_comb begin
      w_pc_nxt  = r_pc;
      w_ir_nxt  = r_ir;
      w_imm_nxt = r_imm;
      w_din_nxt = r_din;
      case (r_state)
         S_LATCH: begin
            w_ir_nxt = io_bus.rom_data;
            w_pc_nxt = r_pc + 5'd1;
            // DIN presents the instruction in ISSUE; a HALT or MVI word leaves DIN as is.
            if (w_next_state == S_ISSUE) w_din_nxt = io_bus.rom_data;
            else                         w_din_nxt = r_din;
         end
         S_IMM_LATCH: begin
            w_imm_nxt = io_bus.rom_data;
            w_pc_nxt  = r_pc + 5'd1;
            w_din_nxt = r_ir;
         end
         S_ISSUE: begin
            // During EXEC the processor sees the immediate of an MVI, else the instruction.
            if (w_ir_is_mvi) w_din_nxt = r_imm;
            else             w_din_nxt = r_ir;
         end
         S_HALT: begin
            if (i_start) w_pc_nxt = 5'd0;
            else         w_pc_nxt = r_pc;
         end
         default: begin
            w_pc_nxt = r_pc;
         end
      endcase

      if ((w_next_state == S_FETCH) || (w_next_state == S_IMM_FETCH)) w_rom_addr_nxt = w_pc_nxt;
      else                                                             w_rom_addr_nxt = r_rom_addr;

      w_run_nxt    = (w_next_state == S_ISSUE);
      w_busy_nxt   = (w_next_state != S_IDLE) && (w_next_state != S_HALT);
      w_halted_nxt = (w_next_state == S_HALT);
   end

   // Registered outputs and instruction/immediate holding registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc       <= 5'd0;
         r_rom_addr <= 5'd0;
         r_ir       <= 8'd0;
         r_imm      <= 8'd0;
         r_din      <= 8'd0;
         r_run      <= 1'b0;
         r_busy     <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_pc       <= w_pc_nxt;
         r_rom_addr <= w_rom_addr_nxt;
         r_ir       <= w_ir_nxt;
         r_imm      <= w_imm_nxt;
         r_din      <= w_din_nxt;
         r_run      <= w_run_nxt;
         r_busy     <= w_busy_nxt;
         r_halted   <= w_halted_nxt;
      end
   end

`ifdef INSTR_ISSUER_WATCHDOG_EN
   // Watchdog next values: count EXEC cycles, flag on expiry, clear on restart.
   always_comb begin
      w_wdt_cnt_nxt = r_wdt_cnt;
      w_wdt_err_nxt = r_wdt_err;
      if ((r_state != S_EXEC) && (w_next_state == S_EXEC)) w_wdt_cnt_nxt = 5'd0;
      else if (r_state == S_EXEC)                          w_wdt_cnt_nxt = r_wdt_cnt + 5'd1;
      else                                                 w_wdt_cnt_nxt = r_wdt_cnt;
      if (w_wdt_expire)                                                w_wdt_err_nxt = 1'b1;
      else if (((r_state == S_IDLE) || (r_state == S_HALT)) && i_start) w_wdt_err_nxt = 1'b0;
      else                                                             w_wdt_err_nxt = r_wdt_err;
   end

   // Watchdog registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wdt_cnt <= 5'd0;
         r_wdt_err <= 1'b0;
      end else begin
         r_wdt_cnt <= w_wdt_cnt_nxt;
         r_wdt_err <= w_wdt_err_nxt;
      end
   end

   assign o_wdt_err = r_wdt_err;
`endif

   assign io_bus.rom_addr = r_rom_addr;
   assign io_bus.din      = r_din;
   assign io_bus.run_sig  = r_run;
   assign o_busy          = r_busy;
   assign o_halted        = r_halted;
   assign o_pc            = r_pc;

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: behavioural ROM with one-cycle read latency,
// an auto-DONE processor stand-in, and a scoreboard of expected DIN words per issue.
// Watchdog scenario compiles in when INSTR_ISSUER_WATCHDOG_EN is defined.
module tb_instr_issuer;
   logic       clk;
   logic       rst;
   logic       start;
   logic       busy;
   logic       halted;
   logic [4:0] pc;
`ifdef INSTR_ISSUER_WATCHDOG_EN
   logic       wdt_err;
`endif

   instr_issuer_if bus ();

   instr_issuer dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_start  (start),
      .io_bus   (bus),
      .o_busy   (busy),
      .o_halted (halted),
      .o_pc     (pc)
`ifdef INSTR_ISSUER_WATCHDOG_EN
      ,
      .o_wdt_err(wdt_err)
`endif
   );

   logic [7:0] rom [0:31];
   int checks = 0;
   int errors = 0;
   int done_lat = 0;
   bit done_armed = 1'b0;
   int done_cd = 0;

   logic [7:0] exp_issue[$];
   logic [7:0] exp_exec[$];
   logic [7:0] got_issue[$];
   logic [7:0] got_exec[$];
   logic [7:0] got_done_din[$];
   int         run_cyc[$];
   logic [4:0] pc_trace[$];
   int         fetch_cyc;
   logic [4:0] fetch_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM read data appears one cycle after the address.
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   task automatic fill_rom(input logic [7:0] v);
      for (int a = 0; a < 32; a++) rom[a] = v;
   endtask

   // One clock; samples are taken 1 time unit after the edge. DONE_SIG is pulsed
   // done_lat cycles after an observed RUN_SIG when done_lat > 0.
   task automatic step();
      @(posedge clk);
      #1;
      bus.done_sig = 1'b0;
      if (done_armed) begin
         done_cd--;
         if (done_cd <= 0) begin
            bus.done_sig = 1'b1;
            done_armed   = 1'b0;
         end
      end
      if (bus.run_sig === 1'b1 && done_lat > 0) begin
         done_armed = 1'b1;
         done_cd    = done_lat;
      end
   endtask

   // Runs the issuer, recording issued words, EXEC words and the PC trace (no checking).
   task automatic run_prog(input bit do_start, input int max_cycles);
      logic prev_run;
      prev_run = 1'b0;
      got_issue.delete(); got_exec.delete(); got_done_din.delete();
      run_cyc.delete(); pc_trace.delete();
      fetch_cyc  = -1;
      fetch_addr = 5'd0;
      done_armed = 1'b0;
      if (do_start) start = 1'b1;
      for (int i = 0; i < max_cycles; i++) begin
         step();
         start = 1'b0;
         if (fetch_cyc < 0 && busy === 1'b1) begin
            fetch_cyc  = i;
            fetch_addr = bus.rom_addr;
         end
         if (prev_run === 1'b1) got_exec.push_back(bus.din);
         if (bus.done_sig === 1'b1) got_done_din.push_back(bus.din);
         if (bus.run_sig === 1'b1) begin
            got_issue.push_back(bus.din);
            run_cyc.push_back(i);
         end
         if (pc_trace.size() == 0 || pc_trace[$] !== pc) pc_trace.push_back(pc);
         prev_run = bus.run_sig;
         if (halted === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bus.done_sig = 1'b0;
      step(); step();
      checks++; if (bus.rom_addr !== 5'd0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 00", bus.rom_addr); end
      checks++; if (bus.din !== 8'd0) begin errors++; $display("FAIL reset_din: got %h expected 00", bus.din); end
      checks++; if (bus.run_sig !== 1'b0) begin errors++; $display("FAIL reset_run: got %b expected 0", bus.run_sig); end
      checks++; if ({busy, halted} !== 2'b00) begin errors++; $display("FAIL reset_busy_halted: got %b expected 00", {busy, halted}); end
      checks++; if (pc !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc); end
`ifdef INSTR_ISSUER_WATCHDOG_EN
      checks++; if (wdt_err !== 1'b0) begin errors++; $display("FAIL reset_wdt_err: got %b expected 0", wdt_err); end
`endif
      rst = 1'b0;
      bus.done_sig = 1'b1;
      step(); step();
      checks++; if ({busy, bus.run_sig, pc} !== 7'd0) begin errors++; $display("FAIL idle_hold: got busy/run/pc %b expected all 0", {busy, bus.run_sig, pc}); end
   endtask

   task automatic test_single();
      logic [7:0] e;
      logic [7:0] g;
      fill_rom(8'hE0);
      rom[0] = 8'h40; rom[1] = 8'hE0;
      exp_issue.push_back(8'h40); exp_exec.push_back(8'h40);
      done_lat = 2;
      run_prog(1'b1, 60);
      while (exp_issue.size() != 0) begin
         e = exp_issue.pop_front(); checks++;
         if (got_issue.size() == 0) begin errors++; $display("FAIL single_issue_din: got none expected %h", e); end
         else begin g = got_issue.pop_front(); if (g !== e) begin errors++; $display("FAIL single_issue_din: got %h expected %h", g, e); end end
      end
      while (exp_exec.size() != 0) begin
         e = exp_exec.pop_front(); checks++;
         if (got_exec.size() == 0) begin errors++; $display("FAIL single_exec_din: got none expected %h", e); end
         else begin g = got_exec.pop_front(); if (g !== e) begin errors++; $display("FAIL single_exec_din: got %h expected %h", g, e); end end
      end
      checks++; if (got_issue.size() != 0) begin errors++; $display("FAIL single_extra_runs: got %0d extra expected 0", got_issue.size()); end
      checks++; if (fetch_addr !== 5'd0) begin errors++; $display("FAIL single_fetch_addr: got %0d expected 0", fetch_addr); end
      checks++; if (run_cyc.size() == 0 || run_cyc[0] - fetch_cyc != 2) begin errors++; $display("FAIL single_latency: got %0d runs/first at %0d expected offset 2 from %0d", run_cyc.size(), (run_cyc.size() == 0) ? -1 : run_cyc[0], fetch_cyc); end
      checks++; if ({halted, busy} !== 2'b10) begin errors++; $display("FAIL single_halted: got halted/busy %b expected 10", {halted, busy}); end
      checks++; if (pc !== 5'd2) begin errors++; $display("FAIL single_pc: got %0d expected 2", pc); end
      checks++; if (bus.din !== 8'h40) begin errors++; $display("FAIL single_din_hold: got %h expected 40", bus.din); end
   endtask

   task automatic test_mvi();
      logic [7:0] e;
      logic [7:0] g;
      fill_rom(8'hE0);
      rom[0] = 8'h20; rom[1] = 8'h5A; rom[2] = 8'hE0;
      exp_issue.push_back(8'h20); exp_exec.push_back(8'h5A);
      done_lat = 2;
      run_prog(1'b1, 60);
      while (exp_issue.size() != 0) begin
         e = exp_issue.pop_front(); checks++;
         if (got_issue.size() == 0) begin errors++; $display("FAIL mvi_issue_din: got none expected %h", e); end
         else begin g = got_issue.pop_front(); if (g !== e) begin errors++; $display("FAIL mvi_issue_din: got %h expected %h", g, e); end end
      end
      while (exp_exec.size() != 0) begin
         e = exp_exec.pop_front(); checks++;
         if (got_exec.size() == 0) begin errors++; $display("FAIL mvi_exec_din: got none expected %h", e); end
         else begin g = got_exec.pop_front(); if (g !== e) begin errors++; $display("FAIL mvi_exec_din: got %h expected %h", g, e); end end
      end
      checks++; if (got_done_din.size() != 1 || got_done_din[0] !== 8'h5A) begin errors++; $display("FAIL mvi_din_at_done: got %0d samples first %h expected 1 sample 5a", got_done_din.size(), (got_done_din.size() == 0) ? 8'hxx : got_done_din[0]); end
      checks++; if (run_cyc.size() != 1 || run_cyc[0] - fetch_cyc != 4) begin errors++; $display("FAIL mvi_latency: got %0d runs expected 1 run at offset 4 from %0d", run_cyc.size(), fetch_cyc); end
      checks++; if ({halted, busy, pc} !== {2'b10, 5'd3}) begin errors++; $display("FAIL mvi_halt_pc: got halted/busy %b pc %0d expected 10 pc 3", {halted, busy}, pc); end
   endtask

   task automatic test_done_filter();
      fill_rom(8'hE0);
      rom[0] = 8'h40; rom[1] = 8'h60; rom[2] = 8'hE0;
      done_lat = 0; done_armed = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      checks++; if ({busy, bus.run_sig, bus.rom_addr} !== {2'b10, 5'd0}) begin errors++; $display("FAIL dfilt_fetch: got busy/run %b addr %0d expected 10 addr 0", {busy, bus.run_sig}, bus.rom_addr); end
      bus.done_sig = 1'b1;
      step();
      step();
      checks++; if ({bus.run_sig, bus.din} !== {1'b1, 8'h40}) begin errors++; $display("FAIL dfilt_issue: got run %b din %h expected 1 40", bus.run_sig, bus.din); end
      bus.done_sig = 1'b1;
      step();
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         start = 1'b0;
         checks++; if ({busy, bus.run_sig, halted, pc} !== {3'b100, 5'd1}) begin errors++; $display("FAIL dfilt_exec_wait: got busy/run/halted %b pc %0d expected 100 pc 1", {busy, bus.run_sig, halted}, pc); end
      end
      bus.done_sig = 1'b1;
      done_lat = 2;
      run_prog(1'b0, 40);
      checks++; if (got_issue.size() != 1 || got_issue[0] !== 8'h60) begin errors++; $display("FAIL dfilt_second_issue: got %0d runs expected 1 run of 60", got_issue.size()); end
      checks++; if ({halted, pc} !== {1'b1, 5'd3}) begin errors++; $display("FAIL dfilt_halt: got halted %b pc %0d expected 1 pc 3", halted, pc); end
   endtask

   task automatic test_wrap();
      int bad;
      bit found;
      fill_rom(8'h40);
      done_lat = 1;
      run_prog(1'b1, 160);
      bad = 0;
      foreach (got_issue[k]) if (got_issue[k] !== 8'h40) bad++;
      found = 1'b0;
      for (int k = 0; k + 3 < pc_trace.size(); k++)
         if (pc_trace[k] == 5'd30 && pc_trace[k+1] == 5'd31 && pc_trace[k+2] == 5'd0 && pc_trace[k+3] == 5'd1) found = 1'b1;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL wrap_no_halt: got %b expected 0", halted); end
      checks++; if (got_issue.size() != 40) begin errors++; $display("FAIL wrap_run_count: got %0d expected 40", got_issue.size()); end
      checks++; if (bad != 0) begin errors++; $display("FAIL wrap_issue_din: got %0d wrong words expected 0", bad); end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL wrap_pc_seq: got %b expected 1 for 30,31,0,1", found); end
   endtask

   task automatic test_reset_exec();
      int  nrun;
      bit  prev;
      bit  reached;
      logic [7:0] e;
      rst = 1'b1; step(); rst = 1'b0;
      fill_rom(8'h40);
      rom[0] = 8'h41;
      done_lat = 0; done_armed = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      nrun = 0; prev = 1'b0; reached = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (prev && nrun == 4) begin reached = 1'b1; break; end
         if (prev) bus.done_sig = 1'b1;
         if (bus.run_sig === 1'b1) nrun++;
         prev = (bus.run_sig === 1'b1);
      end
      checks++; if ({reached, busy, pc} !== {2'b11, 5'd4}) begin errors++; $display("FAIL rexec_reach: got reached/busy %b pc %0d expected 11 pc 4", {reached, busy}, pc); end
      rst = 1'b1; start = 1'b1; bus.done_sig = 1'b1;
      step();
      rst = 1'b0; start = 1'b0;
      checks++; if ({bus.rom_addr, bus.din, bus.run_sig, busy, halted, pc} !== 21'd0) begin errors++; $display("FAIL rexec_reset_vals: got addr %0d din %h run/busy/halted %b pc %0d expected all 0", bus.rom_addr, bus.din, {bus.run_sig, busy, halted}, pc); end
      step();
      checks++; if ({bus.run_sig, busy} !== 2'b00) begin errors++; $display("FAIL rexec_idle: got run/busy %b expected 00", {bus.run_sig, busy}); end
      exp_issue.push_back(8'h41);
      done_lat = 1;
      run_prog(1'b1, 3);
      checks++; if (fetch_addr !== 5'd0 || fetch_cyc != 0) begin errors++; $display("FAIL rexec_restart_addr: got %0d at cycle %0d expected 0 at 0", fetch_addr, fetch_cyc); end
      e = exp_issue.pop_front();
      checks++; if (got_issue.size() != 1 || got_issue[0] !== e) begin errors++; $display("FAIL rexec_restart_issue: got %0d runs expected 1 run of %h", got_issue.size(), e); end
   endtask

   task automatic test_watchdog();
      int j;
      bit seen;
      rst = 1'b1; step(); rst = 1'b0;
      fill_rom(8'h40);
      done_lat = 0; done_armed = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.run_sig === 1'b1) begin seen = 1'b1; break; end
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL wdt_run_seen: got %b expected 1", seen); end
`ifdef INSTR_ISSUER_WATCHDOG_EN
      j = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         j++;
         if (halted === 1'b1) break;
      end
      checks++; if (j != 17) begin errors++; $display("FAIL wdt_timeout_cycle: got halt after %0d edges expected 17", j); end
      checks++; if ({halted, busy, wdt_err} !== 3'b101) begin errors++; $display("FAIL wdt_flags: got halted/busy/wdt %b expected 101", {halted, busy, wdt_err}); end
      start = 1'b1; step(); start = 1'b0;
      checks++; if ({busy, wdt_err} !== 2'b10) begin errors++; $display("FAIL wdt_restart: got busy/wdt %b expected 10", {busy, wdt_err}); end
`else
      j = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (halted === 1'b1) j++;
      end
      checks++; if ({j == 0, busy} !== 2'b11) begin errors++; $display("FAIL exec_no_timeout: got halted cycles %0d busy %b expected 0 and 1", j, busy); end
`endif
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      bus.done_sig = 1'b0;
      fill_rom(8'hE0);
      test_reset();
      test_single();
      test_mvi();
      test_done_filter();
      test_wrap();
      test_reset_exec();
      test_watchdog();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
